// File: rtl/fme_row_load_ctrl.sv
// fme_row_load_ctrl
//   Load sequencer for one 16-lane pixel register bank in the FME datapath.
//   It loads ROWS pixel rows per block from the reference fetch stage into the
//   bank and hands each row to the interpolator with a valid/ready handshake.
//   The bank is treated as a one-deep buffer: a new row may be captured in the
//   same cycle the held row is consumed, so a block can stream at one row per
//   cycle.
//
// Parameters
//   ROWS   rows per block (2..31)
//   CNT_W  counter / row_idx width, 2**CNT_W > ROWS
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   start       begins a block (sampled only in IDLE)
//   in_valid    upstream row present on the bank inputs
//   in_ready    controller accepts the upstream row this cycle
//   reg_enable  bank enable; the bank captures its inputs at the next edge
//   out_valid   bank holds an unconsumed row
//   out_ready   interpolator consumes the bank row this cycle
//   row_idx     index of the row currently held in the bank
//   busy        high while filling a block
//   done        one-cycle pulse after the last row of the block is consumed
//   abort       (only with FME_LOAD_ABORT_EN defined) discards the current block
//
// Build option
//   FME_LOAD_ABORT_EN  adds the abort input. Without it a block ends only
//                      through the done path or reset.

module fme_row_load_ctrl #(
  parameter int ROWS  = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             reg_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] row_idx,
  output logic             busy,
`ifdef FME_LOAD_ABORT_EN
  input  logic             abort,
`endif
  output logic             done
);

  localparam logic [CNT_W-1:0] ROWS_C = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             full, full_nxt;
  logic [CNT_W-1:0] load_cnt, load_cnt_nxt;
  logic [CNT_W-1:0] cons_cnt, cons_cnt_nxt;
  logic [CNT_W-1:0] row_idx_nxt;
  logic             consume;

  // Counters stop at ROWS so they can never wrap inside a block.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= ROWS_C) ? ROWS_C : v + 1'b1;
  endfunction

  assign out_valid = full;

  always_comb begin
    state_nxt    = state;
    full_nxt     = full;
    load_cnt_nxt = load_cnt;
    cons_cnt_nxt = cons_cnt;
    row_idx_nxt  = row_idx;

    // A load is allowed while the bank is empty or is being drained this cycle.
    in_ready   = (state == FILL) && (load_cnt < ROWS_C) && (!full || out_ready);
    reg_enable = in_valid && in_ready;
    consume    = full && out_ready;
    busy       = (state == FILL);
    done       = (state == DONE);

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = FILL;
          load_cnt_nxt = '0;
          cons_cnt_nxt = '0;
          row_idx_nxt  = '0;
        end
      end
      FILL: begin
        if (reg_enable) begin
          load_cnt_nxt = sat_inc(load_cnt);
          row_idx_nxt  = load_cnt;
          full_nxt     = 1'b1;
        end else if (consume) begin
          full_nxt     = 1'b0;
        end
        if (consume) begin
          cons_cnt_nxt = sat_inc(cons_cnt);
          if (cons_cnt == LAST_C) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

`ifdef FME_LOAD_ABORT_EN
    // Abort outranks every load, consume and done pulse of the same cycle.
    if (abort && (state != IDLE)) begin
      state_nxt    = IDLE;
      full_nxt     = 1'b0;
      load_cnt_nxt = '0;
      cons_cnt_nxt = '0;
      row_idx_nxt  = '0;
      done         = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      full     <= 1'b0;
      load_cnt <= '0;
      cons_cnt <= '0;
      row_idx  <= '0;
    end else begin
      state    <= state_nxt;
      full     <= full_nxt;
      load_cnt <= load_cnt_nxt;
      cons_cnt <= cons_cnt_nxt;
      row_idx  <= row_idx_nxt;
    end
  end

endmodule

// File: tb/tb_fme_row_load_ctrl.sv
module tb_fme_row_load_ctrl;

  localparam int ROWS  = 4;
  localparam int CNT_W = 5;

  logic             clock;
  logic             reset;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             reg_enable;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] row_idx;
  logic             busy;
  logic             done;
`ifdef FME_LOAD_ABORT_EN
  logic             abort;
`endif

  fme_row_load_ctrl #(.ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reg_enable (reg_enable),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .row_idx    (row_idx),
    .busy       (busy),
`ifdef FME_LOAD_ABORT_EN
    .abort      (abort),
`endif
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic     s;
    logic     iv;
    logic     ordy;
    logic     ir;
    logic     re;
    logic     ov;
    int       idx;
    logic     bz;
    logic     dn;
  } vec_t;

  vec_t tab [30];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic s, iv, ordy, ir, re, ov,
                              input int idx, input logic bz, dn);
    vec_t v;
    v.s = s; v.iv = iv; v.ordy = ordy;
    v.ir = ir; v.re = re; v.ov = ov; v.idx = idx; v.bz = bz; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the outputs before the edge, then clock.
  task automatic run(input int i);
    start     = tab[i].s;
    in_valid  = tab[i].iv;
    out_ready = tab[i].ordy;
    #1;
    chk($sformatf("v%0d.in_ready", i),   int'(in_ready),   int'(tab[i].ir));
    chk($sformatf("v%0d.reg_enable", i), int'(reg_enable), int'(tab[i].re));
    chk($sformatf("v%0d.out_valid", i),  int'(out_valid),  int'(tab[i].ov));
    chk($sformatf("v%0d.row_idx", i),    int'(row_idx),    tab[i].idx);
    chk($sformatf("v%0d.busy", i),       int'(busy),       int'(tab[i].bz));
    chk($sformatf("v%0d.done", i),       int'(done),       int'(tab[i].dn));
    @(posedge clock);
    #1;
  endtask

  initial begin
    //              s  iv or | ir re ov idx bz dn
    // streaming block, in_valid and out_ready high
    tab[0]  = mk(1, 0, 0,  0, 0, 0, 0, 0, 0);
    tab[1]  = mk(0, 1, 1,  1, 1, 0, 0, 1, 0);
    tab[2]  = mk(0, 1, 1,  1, 1, 1, 0, 1, 0);
    tab[3]  = mk(0, 1, 1,  1, 1, 1, 1, 1, 0);
    tab[4]  = mk(0, 1, 1,  1, 1, 1, 2, 1, 0);
    tab[5]  = mk(0, 1, 1,  0, 0, 1, 3, 1, 0);
    tab[6]  = mk(0, 1, 1,  0, 0, 0, 3, 0, 1);
    tab[7]  = mk(0, 1, 0,  0, 0, 0, 3, 0, 0);
    // backpressure, extra upstream row, stray start pulses
    tab[8]  = mk(1, 0, 0,  0, 0, 0, 3, 0, 0);
    tab[9]  = mk(0, 1, 0,  1, 1, 0, 0, 1, 0);
    tab[10] = mk(1, 1, 0,  0, 0, 1, 0, 1, 0);
    tab[11] = mk(0, 1, 1,  1, 1, 1, 0, 1, 0);
    tab[12] = mk(0, 1, 1,  1, 1, 1, 1, 1, 0);
    tab[13] = mk(1, 1, 1,  1, 1, 1, 2, 1, 0);
    tab[14] = mk(0, 1, 0,  0, 0, 1, 3, 1, 0);
    tab[15] = mk(0, 1, 1,  0, 0, 1, 3, 1, 0);
    tab[16] = mk(1, 1, 0,  0, 0, 0, 3, 0, 1);
    tab[17] = mk(0, 0, 0,  0, 0, 0, 3, 0, 0);
    // lead-in to the mid-block reset
    tab[18] = mk(1, 0, 0,  0, 0, 0, 3, 0, 0);
    tab[19] = mk(0, 1, 1,  1, 1, 0, 0, 1, 0);
    tab[20] = mk(0, 1, 1,  1, 1, 1, 0, 1, 0);
    tab[21] = mk(0, 1, 1,  1, 1, 1, 1, 1, 0);
    // new block after reset release
    tab[22] = mk(1, 0, 0,  0, 0, 0, 0, 0, 0);
    tab[23] = mk(0, 1, 0,  1, 1, 0, 0, 1, 0);
    tab[24] = mk(0, 0, 0,  0, 0, 1, 0, 1, 0);
    // abort with a simultaneous load (abort raised for entry 28 only)
    tab[25] = mk(1, 0, 0,  0, 0, 0, 0, 0, 0);
    tab[26] = mk(0, 1, 1,  1, 1, 0, 0, 1, 0);
    tab[27] = mk(0, 1, 1,  1, 1, 1, 0, 1, 0);
    tab[28] = mk(0, 1, 1,  1, 1, 1, 1, 1, 0);
    tab[29] = mk(0, 1, 1,  0, 0, 0, 0, 0, 0);

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef FME_LOAD_ABORT_EN
    abort = 1'b0;
`endif

    // reset held for three cycles, inputs active
    in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst.in_ready",   int'(in_ready),   0);
    chk("rst.reg_enable", int'(reg_enable), 0);
    chk("rst.out_valid",  int'(out_valid),  0);
    chk("rst.row_idx",    int'(row_idx),    0);
    chk("rst.busy",       int'(busy),       0);
    chk("rst.done",       int'(done),       0);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i <= 21; i++) run(i);

    // bank holds row 2; reset between edges must clear at once
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst.out_valid", int'(out_valid), 0);
    chk("midrst.busy",      int'(busy),      0);
    chk("midrst.row_idx",   int'(row_idx),   0);
    chk("midrst.in_ready",  int'(in_ready),  0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 22; i <= 24; i++) run(i);

`ifdef FME_LOAD_ABORT_EN
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 25; i <= 27; i++) run(i);
    abort = 1'b1;
    run(28);
    abort = 1'b0;
    run(29);
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("abort.nodone%0d", c), int'(done), 0);
      @(posedge clock);
      #1;
    end
    // a following block runs to completion
    begin
      int loads = 0;
      int seen  = 0;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 20 && seen == 0; c++) begin
        #1;
        if (reg_enable) loads++;
        if (done) seen = 1;
        @(posedge clock);
        #1;
      end
      chk("abort.next_done_seen", seen,  1);
      chk("abort.next_loads",     loads, ROWS);
      in_valid = 1'b0; out_ready = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
